// File: rtl/strip_frame_buffer.sv
// Double-buffered strip frame store behind an asynchronous SRAM-style host bus.
// Host fills the back buffer while LED banks read the front; CTRL requests swap/go once banks are idle.
module strip_frame_buffer #(
    parameter int FRAME_LENGTH = 16,
    parameter int STRIPS       = 72,
    parameter int BANKS        = 4,
    parameter int ADDR_BITS    = 2,
    localparam int IDX_W       = $clog2(STRIPS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    bus_ne,
    input  logic                    bus_noe,
    input  logic                    bus_nwe,
    input  logic [ADDR_BITS-1:0]    bus_addr,
    input  logic [FRAME_LENGTH-1:0] bus_din,
    output logic [FRAME_LENGTH-1:0] bus_dout,
    output logic                    bus_oe,
    input  logic [BANKS-1:0]        bank_idle,
    output logic                    go,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [FRAME_LENGTH-1:0] rd_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FIRE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRIPS - 1);

    state_t                  r_state;
    logic                    r_ne_s1, r_ne_s2;
    logic                    r_noe_s1, r_noe_s2;
    logic                    r_nwe_s1, r_nwe_s2, r_nwe_d;
    logic                    r_bus_oe;
    logic [FRAME_LENGTH-1:0] r_bus_dout;
    logic                    r_go;
    logic                    r_lat_go, r_lat_swap;
    logic                    r_front_sel;
    logic                    r_full, r_overrun;
    logic [IDX_W-1:0]        r_wr_ptr;
    logic [FRAME_LENGTH-1:0] r_rd_data;
    logic [FRAME_LENGTH-1:0] r_buf0 [STRIPS];
    logic [FRAME_LENGTH-1:0] r_buf1 [STRIPS];

    logic                    w_strobe;
    logic                    w_wr_ctrl, w_wr_data, w_wr_ptr;
    logic                    w_ptr_ok;
    logic [FRAME_LENGTH-1:0] w_stat;
    logic [FRAME_LENGTH-1:0] w_rd_reg;

    // Address and data are read straight from the pins: the bus holds them through the strobe.
    assign w_strobe  = r_nwe_s2 && !r_nwe_d && !r_ne_s2;
    assign w_wr_ctrl = w_strobe && (bus_addr == ADDR_BITS'(1));
    assign w_wr_data = w_strobe && (bus_addr == ADDR_BITS'(2));
    assign w_wr_ptr  = w_strobe && (bus_addr == ADDR_BITS'(3));
    assign w_ptr_ok  = bus_din < FRAME_LENGTH'(STRIPS);

    always_comb begin
        w_stat              = '0;
        w_stat[BANKS-1:0]   = bank_idle;
        w_stat[8]           = r_front_sel;
        w_stat[9]           = (r_state != ST_IDLE);
        w_stat[10]          = r_full;
        w_stat[11]          = r_overrun;
        w_rd_reg            = '0;
        if (bus_addr == ADDR_BITS'(0))
            w_rd_reg = w_stat;
        else if (bus_addr == ADDR_BITS'(3))
            w_rd_reg = FRAME_LENGTH'(r_wr_ptr);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ne_s1     <= 1'b1;
            r_ne_s2     <= 1'b1;
            r_noe_s1    <= 1'b1;
            r_noe_s2    <= 1'b1;
            r_nwe_s1    <= 1'b1;
            r_nwe_s2    <= 1'b1;
            r_nwe_d     <= 1'b1;
            r_bus_oe    <= 1'b0;
            r_bus_dout  <= '0;
            r_go        <= 1'b0;
            r_lat_go    <= 1'b0;
            r_lat_swap  <= 1'b0;
            r_front_sel <= 1'b0;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ptr    <= '0;
            r_state     <= ST_IDLE;
        end else begin
            r_ne_s1    <= bus_ne;
            r_ne_s2    <= r_ne_s1;
            r_noe_s1   <= bus_noe;
            r_noe_s2   <= r_noe_s1;
            r_nwe_s1   <= bus_nwe;
            r_nwe_s2   <= r_nwe_s1;
            r_nwe_d    <= r_nwe_s2;
            r_bus_oe   <= !r_ne_s2 && !r_noe_s2;
            r_bus_dout <= w_rd_reg;
            r_go       <= 1'b0;

            if (w_wr_data) begin
                if (r_full)
                    r_overrun <= 1'b1;
                if (r_wr_ptr == LAST_IDX) begin
                    r_full   <= 1'b1;
                    r_wr_ptr <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
            if (w_wr_ptr && w_ptr_ok)
                r_wr_ptr <= bus_din[IDX_W-1:0];
            if (w_wr_ctrl && bus_din[2])
                r_overrun <= 1'b0;

            // The swap in FIRE comes last so it wins over a same-cycle DATA/PTR pointer update.
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ctrl && (bus_din[0] || bus_din[1])) begin
                        r_lat_go   <= bus_din[0];
                        r_lat_swap <= bus_din[1];
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (&bank_idle)
                        r_state <= ST_FIRE;
                end
                ST_FIRE: begin
                    if (r_lat_swap) begin
                        r_front_sel <= !r_front_sel;
                        r_wr_ptr    <= '0;
                        r_full      <= 1'b0;
                    end
                    r_go    <= r_lat_go;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_data) begin
            if (r_front_sel)
                r_buf0[r_wr_ptr] <= bus_din;
            else
                r_buf1[r_wr_ptr] <= bus_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_rd_data <= '0;
        else if ({1'b0, rd_idx} < (IDX_W + 1)'(STRIPS))
            r_rd_data <= r_front_sel ? r_buf1[rd_idx] : r_buf0[rd_idx];
        else
            r_rd_data <= '0;
    end

    assign bus_dout = r_bus_dout;
    assign bus_oe   = r_bus_oe;
    assign go       = r_go;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_strip_frame_buffer.sv
// Bench for strip_frame_buffer: directed bus transactions against a transaction-level model
// of the register map and the two frame buffers, plus hand-computed literal expectations.
module tb_strip_frame_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bus_ne = 1'b1;
    logic        bus_noe = 1'b1;
    logic        bus_nwe = 1'b1;
    logic [1:0]  bus_addr = '0;
    logic [15:0] bus_din = '0;
    logic [15:0] bus_dout;
    logic        bus_oe;
    logic [3:0]  bank_idle = 4'hF;
    logic        go;
    logic [6:0]  rd_idx = '0;
    logic [15:0] rd_data;

    strip_frame_buffer dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus_ne    (bus_ne),
        .bus_noe   (bus_noe),
        .bus_nwe   (bus_nwe),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_oe    (bus_oe),
        .bank_idle (bank_idle),
        .go        (go),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [15:0] m_buf   [2][72];
    bit          m_known [2][72];
    bit          m_front, m_full, m_ovr, m_busy, m_lat_go, m_lat_swap;
    bit          m_stable = 1'b0;
    bit          m_go_allowed = 1'b0;
    logic [6:0]  m_ptr;
    int          m_go_exp = 0;
    int          go_seen  = 0;
    logic        go_prev  = 1'b0;
    logic [6:0]  idx_q    = '0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {4'b0, m_ovr, m_full, m_busy, m_front, 4'b0, bank_idle};
            2'd3:    return {9'b0, m_ptr};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_front = 0; m_full = 0; m_ovr = 0; m_busy = 0;
        m_lat_go = 0; m_lat_swap = 0; m_ptr = '0;
    endtask

    // Compare process: front-buffer read data and go pulse legality every cycle.
    always @(posedge clk) idx_q <= rd_idx;

    always @(negedge clk) begin
        if (resetn) begin
            if (m_stable && m_known[m_front][idx_q])
                check("rd_data", rd_data, m_buf[m_front][idx_q]);
            if (!m_go_allowed)
                check("go_quiet", {15'b0, go}, 16'h0000);
            check("go_width", {15'b0, go & go_prev}, 16'h0000);
            if (go) go_seen++;
            go_prev = go;
        end else begin
            go_prev = 1'b0;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_addr = a; bus_din = d; bus_ne = 1'b0;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b0;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b1;
        repeat (4) @(negedge clk);
        bus_ne = 1'b1;
        case (a)
            2'd1: begin
                if (d[2]) m_ovr = 0;
                if (!m_busy && (d[0] || d[1])) begin
                    m_busy = 1; m_lat_go = d[0]; m_lat_swap = d[1];
                end
            end
            2'd2: begin
                m_buf[!m_front][m_ptr]   = d;
                m_known[!m_front][m_ptr] = 1'b1;
                if (m_full) m_ovr = 1;
                if (m_ptr == 7'd71) begin
                    m_full = 1; m_ptr = '0;
                end else begin
                    m_ptr = m_ptr + 7'd1;
                end
            end
            2'd3: if (d < 16'd72) m_ptr = d[6:0];
            default: ;
        endcase
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
        @(negedge clk);
        bus_addr = a; bus_ne = 1'b0; bus_noe = 1'b0;
        repeat (4) @(negedge clk);
        d = bus_dout; oe = bus_oe;
        bus_ne = 1'b1; bus_noe = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_read(input string name, input logic [1:0] a, output logic [15:0] d);
        logic oe;
        bus_read(a, d, oe);
        check(name, d, m_reg(a));
        check({name, "_oe"}, {15'b0, oe}, 16'h0001);
    endtask

    task automatic release_banks();
        m_stable = 0; m_go_allowed = 1;
        @(negedge clk);
        bank_idle = 4'hF;
        repeat (6) @(negedge clk);
        if (m_lat_swap) begin
            m_front = !m_front; m_ptr = '0; m_full = 0;
        end
        if (m_lat_go) m_go_exp++;
        m_busy = 0; m_go_allowed = 0;
        repeat (2) @(negedge clk);
        m_stable = 1;
    endtask

    task automatic sweep_front();
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            rd_idx = 7'(i);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_go", {15'b0, go}, 16'h0000);
        check("rst_bus_oe", {15'b0, bus_oe}, 16'h0000);
        check("rst_bus_dout", bus_dout, 16'h0000);
        check("rst_rd_data", rd_data, 16'h0000);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        m_stable = 1;

        // bus_oe latency through the synchronisers
        bus_addr = 2'd0; bus_ne = 1'b0; bus_noe = 1'b0;
        repeat (2) @(negedge clk);
        check("oe_lat2", {15'b0, bus_oe}, 16'h0000);
        @(negedge clk);
        check("oe_lat3", {15'b0, bus_oe}, 16'h0001);
        bus_ne = 1'b1; bus_noe = 1'b1;
        repeat (3) @(negedge clk);
        check("oe_off", {15'b0, bus_oe}, 16'h0000);

        check_read("stat_rst", 2'd0, d);
        check("stat_rst_lit", d, 16'h000F);
        check_read("ctrl_rd", 2'd1, d);
        check_read("data_rd", 2'd2, d);
        check_read("ptr_rst", 2'd3, d);

        // Fill the back buffer
        for (int i = 0; i < 72; i++)
            bus_write(2'd2, 16'h1000 + 16'(i));
        check_read("stat_full", 2'd0, d);
        check("stat_full_lit", d, 16'h040F);
        check_read("ptr_wrap", 2'd3, d);
        check("ptr_wrap_lit", d, 16'h0000);

        bus_write(2'd2, 16'h2000);
        check_read("stat_ovr", 2'd0, d);
        check("stat_ovr_lit", d, 16'h0C0F);
        bus_write(2'd1, 16'h0004);
        check_read("stat_clr", 2'd0, d);
        check("stat_clr_lit", d, 16'h040F);

        // Swap+go held off by a busy bank; second CTRL while busy ignored
        bank_idle = 4'hE;
        bus_write(2'd1, 16'h0003);
        check_read("stat_wait", 2'd0, d);
        check("stat_wait_lit", d, 16'h060E);
        bus_write(2'd1, 16'h0001);
        check("go_none", 16'(go_seen), 16'h0000);
        release_banks();
        check("go_one", 16'(go_seen), 16'h0001);
        check("go_model", 16'(go_seen), 16'(m_go_exp));
        check_read("stat_swap", 2'd0, d);
        check("stat_swap_lit", d, 16'h010F);
        @(negedge clk);
        rd_idx = 7'd5;
        @(negedge clk);
        check("rd5_lit", rd_data, 16'h1005);
        sweep_front();

        // Pointer writes
        bus_write(2'd3, 16'd10);
        check_read("ptr10", 2'd3, d);
        check("ptr10_lit", d, 16'd10);
        bus_write(2'd2, 16'hABCD);
        bus_write(2'd3, 16'd72);
        check_read("ptr11", 2'd3, d);
        check("ptr11_lit", d, 16'd11);

        // Swap only, no go: the entry written at index 10 comes to the front
        bank_idle = 4'hE;
        bus_write(2'd1, 16'h0002);
        release_banks();
        check("go_still_one", 16'(go_seen), 16'h0001);
        @(negedge clk);
        rd_idx = 7'd10;
        @(negedge clk);
        check("rd10_lit", rd_data, 16'hABCD);
        sweep_front();

        // Reset during WAIT aborts the go request
        bank_idle = 4'hE;
        bus_write(2'd1, 16'h0001);
        check_read("stat_wait2", 2'd0, d);
        check("stat_wait2_lit", d, 16'h020E);
        m_stable = 0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        bank_idle = 4'hF;
        resetn = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        m_stable = 1;
        check("go_after_rst", 16'(go_seen), 16'h0001);
        check_read("stat_after_rst", 2'd0, d);
        check("stat_after_rst_lit", d, 16'h000F);
        sweep_front();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
